ocx_dlx_tx_gb_ctl: RTL and testbench

Control sequencer for the DLX TX gearbox.
- Generates the 7-bit gearbox sequence counter and the stall slot.
- Walks the TX side through link training: zeros, pattern A, pattern B, sync, control-header training, then data.
- Drives all gearbox control inputs; sits between the TX training logic / tx queue and the gearbox.
- Includes a timeout and failure path.

---
 rtl/ocx_dlx_tx_gb_pkg.sv | 69 ++++++
 rtl/ocx_dlx_tx_gb_seq_cnt.sv | 35 +++
 rtl/ocx_dlx_tx_gb_ctl.sv | 190 +++++++++++++++++++
 tb/tb_ocx_dlx_tx_gb_ctl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocx_dlx_tx_gb_pkg.sv
// Shared types and constants for the DLX TX gearbox control sequencer.
package ocx_dlx_tx_gb_pkg;

  localparam int         CNT_W     = 16;
  localparam logic [6:0] SEQ_MAX   = 7'd65;
  localparam logic [5:0] STALL_SEQ = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    PAT_A,
    PAT_B,
    SYNC,
    TRAIN,
    RUN,
    FAILED
  } gb_state_e;

  typedef struct packed {
    logic gb_reset;
    logic tx_zeros;
    logic tx_a;
    logic tx_b;
    logic tx_sync;
    logic train;
    logic done;
    logic failed;
  } gb_ctl_t;

  // States covered by the training timeout.
  function automatic logic in_training(input gb_state_e s);
    return (s == PAT_A) || (s == PAT_B) || (s == SYNC) || (s == TRAIN);
  endfunction

  function automatic gb_state_e next_train_state(input gb_state_e s);
    gb_state_e n;
    case (s)
      PAT_A:   n = PAT_B;
      PAT_B:   n = SYNC;
      SYNC:    n = TRAIN;
      TRAIN:   n = RUN;
      default: n = s;
    endcase
    return n;
  endfunction

  // Gearbox control word for a given state; exactly one select outside IDLE.
  function automatic gb_ctl_t state_ctl(input gb_state_e s);
    gb_ctl_t c;
    c = '0;
    case (s)
      IDLE: begin
        c.gb_reset = 1'b1;
        c.tx_zeros = 1'b1;
      end
      PAT_A:  c.tx_a    = 1'b1;
      PAT_B:  c.tx_b    = 1'b1;
      SYNC:   c.tx_sync = 1'b1;
      TRAIN:  c.train   = 1'b1;
      RUN:    c.done    = 1'b1;
      FAILED: begin
        c.tx_zeros = 1'b1;
        c.failed   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ocx_dlx_tx_gb_seq_cnt.sv
// Gearbox sequence counter 0..65 with registered stall slot and frame-boundary pulse.
module ocx_dlx_tx_gb_seq_cnt
  import ocx_dlx_tx_gb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [6:0] seq,
  output logic       stall,
  output logic       bnd
);

  logic [6:0] seq_nxt;

  // Held at zero while not running so the first active cycle starts a fresh frame.
  always_comb begin
    seq_nxt = 7'd0;
    if (run && (seq != SEQ_MAX)) begin
      seq_nxt = seq + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq   <= 7'd0;
      stall <= 1'b0;
    end else begin
      seq   <= seq_nxt;
      stall <= (seq_nxt[6:1] == STALL_SEQ);
    end
  end

  assign bnd = (seq == SEQ_MAX);

endmodule

// File: rtl/ocx_dlx_tx_gb_ctl.sv
// DLX TX gearbox control sequencer: training walk, frame-aligned state changes, timeout/failure.
// EDPL inject handshake is built only when OCX_DLX_TX_GB_CTL_EDPL_EN is defined.
module ocx_dlx_tx_gb_ctl
  import ocx_dlx_tx_gb_pkg::*;
#(
  parameter logic [CNT_W-1:0] PAT_MIN_CYC   = 16'd128,
  parameter logic [CNT_W-1:0] SYNC_CYC      = 16'd66,
  parameter logic [CNT_W-1:0] TRAIN_TIMEOUT = 16'hFFFF
) (
  input  logic       dlx_clk,
  input  logic       dlx_reset,
  input  logic       start_train,
  input  logic       rx_pattern_a_det,
  input  logic       rx_pattern_b_det,
  input  logic       rx_link_up,
  input  logic       orx_otx_train_failed,
  output logic [6:0] ctl_gb_seq,
  output logic       ctl_gb_stall,
  output logic       ctl_gb_reset,
  output logic       ctl_gb_train,
  output logic       ctl_gb_tx_zeros,
  output logic       ctl_gb_tx_a_pattern,
  output logic       ctl_gb_tx_b_pattern,
  output logic       ctl_gb_tx_sync_pattern,
  output logic       train_done,
  output logic       train_failed,
  input  logic       cfg_edpl_ena,
  input  logic       cfg_edpl_inj_req,
  input  logic       qb_hwwe,
  output logic       edpl_ena,
  output logic       edpl_inj
);

  gb_state_e        state;
  gb_state_e        state_nxt;
  gb_ctl_t          ctl_q;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] tmo;
  logic             pend_idle;
  logic             pend_adv;
  logic             seq_run;
  logic             bnd;
  logic             adv_now;
  logic             idle_now;
  logic             want_idle;
  logic             want_adv;
  logic             fail_now;
  logic             sync_done;
  logic             tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign seq_run = (state != IDLE);

  ocx_dlx_tx_gb_seq_cnt u_seq_cnt (
    .clk   (dlx_clk),
    .rst   (dlx_reset),
    .run   (seq_run),
    .seq   (ctl_gb_seq),
    .stall (ctl_gb_stall),
    .bnd   (bnd)
  );

  // Counts include the current cycle, so SYNC lasts SYNC_CYC cycles and the
  // timeout fires after TRAIN_TIMEOUT cycles of training.
  assign sync_done = (({1'b0, dwell} + 17'd1) >= {1'b0, SYNC_CYC});
  assign tmo_hit   = (({1'b0, tmo} + 17'd1) >= {1'b0, TRAIN_TIMEOUT});

  always_comb begin
    adv_now  = 1'b0;
    idle_now = 1'b0;
    case (state)
      PAT_A: begin
        adv_now  = (dwell >= PAT_MIN_CYC) && rx_pattern_a_det;
        idle_now = !start_train;
      end
      PAT_B: begin
        adv_now  = (dwell >= PAT_MIN_CYC) && rx_pattern_b_det;
        idle_now = !start_train;
      end
      SYNC: begin
        adv_now  = sync_done;
        idle_now = !start_train;
      end
      TRAIN: begin
        adv_now  = rx_link_up;
        idle_now = !start_train;
      end
      RUN:     idle_now = !start_train || !rx_link_up;
      FAILED:  idle_now = !start_train;
      default: idle_now = 1'b0;
    endcase
  end

  // Mid-frame conditions are latched as pending and acted on at the frame boundary.
  assign want_idle = pend_idle | idle_now;
  assign want_adv  = pend_adv | adv_now;
  assign fail_now  = ((in_training(state) || (state == RUN)) && orx_otx_train_failed) ||
                     (in_training(state) && tmo_hit);

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (start_train) begin
        state_nxt = PAT_A;
      end
    end else if (fail_now) begin
      state_nxt = FAILED;
    end else if (bnd) begin
      if (want_idle) begin
        state_nxt = IDLE;
      end else if (want_adv) begin
        state_nxt = next_train_state(state);
      end
    end
  end

  always_ff @(posedge dlx_clk or posedge dlx_reset) begin
    if (dlx_reset) begin
      state     <= IDLE;
      ctl_q     <= state_ctl(IDLE);
      dwell     <= '0;
      tmo       <= '0;
      pend_idle <= 1'b0;
      pend_adv  <= 1'b0;
    end else begin
      state <= state_nxt;
      ctl_q <= state_ctl(state_nxt);
      if (state_nxt != state) begin
        dwell     <= '0;
        pend_idle <= 1'b0;
        pend_adv  <= 1'b0;
      end else begin
        dwell     <= sat_inc(dwell);
        pend_idle <= want_idle;
        pend_adv  <= want_adv;
      end
      // Timeout spans the whole PAT_A..TRAIN walk, not a single state.
      if (in_training(state_nxt) && in_training(state)) begin
        tmo <= sat_inc(tmo);
      end else begin
        tmo <= '0;
      end
    end
  end

  assign ctl_gb_reset           = ctl_q.gb_reset;
  assign ctl_gb_tx_zeros        = ctl_q.tx_zeros;
  assign ctl_gb_tx_a_pattern    = ctl_q.tx_a;
  assign ctl_gb_tx_b_pattern    = ctl_q.tx_b;
  assign ctl_gb_tx_sync_pattern = ctl_q.tx_sync;
  assign ctl_gb_train           = ctl_q.train;
  assign train_done             = ctl_q.done;
  assign train_failed           = ctl_q.failed;

`ifdef OCX_DLX_TX_GB_CTL_EDPL_EN
  logic edpl_ena_q;
  logic edpl_inj_q;

  // Inject request is held until the gearbox acknowledges; extra requests are dropped.
  always_ff @(posedge dlx_clk or posedge dlx_reset) begin
    if (dlx_reset) begin
      edpl_ena_q <= 1'b0;
      edpl_inj_q <= 1'b0;
    end else begin
      edpl_ena_q <= cfg_edpl_ena;
      if (state_nxt != RUN) begin
        edpl_inj_q <= 1'b0;
      end else if (edpl_inj_q) begin
        if (qb_hwwe) begin
          edpl_inj_q <= 1'b0;
        end
      end else if (cfg_edpl_inj_req && edpl_ena_q && (state == RUN)) begin
        edpl_inj_q <= 1'b1;
      end
    end
  end

  assign edpl_ena = edpl_ena_q;
  assign edpl_inj = edpl_inj_q;
`else
  logic edpl_unused;
  assign edpl_unused = ^{cfg_edpl_ena, cfg_edpl_inj_req, qb_hwwe};
  assign edpl_ena    = 1'b0;
  assign edpl_inj    = 1'b0;
`endif

endmodule

// File: tb/tb_ocx_dlx_tx_gb_ctl.sv
// Self-checking bench: two instances (default and short timeout) against a frame-level reference model.
module tb_ocx_dlx_tx_gb_ctl;

`ifdef OCX_DLX_TX_GB_CTL_EDPL_EN
  localparam bit EDPL = 1'b1;
`else
  localparam bit EDPL = 1'b0;
`endif

  localparam int S_IDLE = 0, S_PAT_A = 1, S_PAT_B = 2, S_SYNC = 3, S_TRAIN = 4, S_RUN = 5, S_FAILED = 6;
  localparam int B_INJ = 0, B_ENA = 1, B_FAILED = 2, B_DONE = 3, B_TRAIN = 4, B_SYNC = 5;
  localparam int B_B = 6, B_A = 7, B_ZEROS = 8, B_RST = 9, B_STALL = 10;

  localparam int P_MIN  = 128;
  localparam int P_SYNC = 66;
  int p_tmo [2] = '{65535, 300};

  logic dlx_clk = 1'b0;
  logic dlx_reset = 1'b1;
  always #5 dlx_clk = ~dlx_clk;

  logic st_i [2], pa_i [2], pb_i [2], lu_i [2], fl_i [2], ena_i [2], req_i [2], hw_i [2];
  logic [6:0] seq_o [2];
  logic stall_o [2], rst_o [2], train_o [2], zeros_o [2], a_o [2], b_o [2], sync_o [2];
  logic done_o [2], failed_o [2], eena_o [2], inj_o [2];

  ocx_dlx_tx_gb_ctl u_dut0 (
    .dlx_clk(dlx_clk), .dlx_reset(dlx_reset), .start_train(st_i[0]),
    .rx_pattern_a_det(pa_i[0]), .rx_pattern_b_det(pb_i[0]), .rx_link_up(lu_i[0]),
    .orx_otx_train_failed(fl_i[0]), .ctl_gb_seq(seq_o[0]), .ctl_gb_stall(stall_o[0]),
    .ctl_gb_reset(rst_o[0]), .ctl_gb_train(train_o[0]), .ctl_gb_tx_zeros(zeros_o[0]),
    .ctl_gb_tx_a_pattern(a_o[0]), .ctl_gb_tx_b_pattern(b_o[0]), .ctl_gb_tx_sync_pattern(sync_o[0]),
    .train_done(done_o[0]), .train_failed(failed_o[0]), .cfg_edpl_ena(ena_i[0]),
    .cfg_edpl_inj_req(req_i[0]), .qb_hwwe(hw_i[0]), .edpl_ena(eena_o[0]), .edpl_inj(inj_o[0])
  );

  ocx_dlx_tx_gb_ctl #(.TRAIN_TIMEOUT(16'd300)) u_dut1 (
    .dlx_clk(dlx_clk), .dlx_reset(dlx_reset), .start_train(st_i[1]),
    .rx_pattern_a_det(pa_i[1]), .rx_pattern_b_det(pb_i[1]), .rx_link_up(lu_i[1]),
    .orx_otx_train_failed(fl_i[1]), .ctl_gb_seq(seq_o[1]), .ctl_gb_stall(stall_o[1]),
    .ctl_gb_reset(rst_o[1]), .ctl_gb_train(train_o[1]), .ctl_gb_tx_zeros(zeros_o[1]),
    .ctl_gb_tx_a_pattern(a_o[1]), .ctl_gb_tx_b_pattern(b_o[1]), .ctl_gb_tx_sync_pattern(sync_o[1]),
    .train_done(done_o[1]), .train_failed(failed_o[1]), .cfg_edpl_ena(ena_i[1]),
    .cfg_edpl_inj_req(req_i[1]), .qb_hwwe(hw_i[1]), .edpl_ena(eena_o[1]), .edpl_inj(inj_o[1])
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;
  int fail_at [2] = '{-1, -1};

  // Reference model: training phase, frame position, cycles in phase, cycles in training.
  int m_st [2] = '{0, 0};
  int m_pos [2] = '{0, 0};
  int m_age [2] = '{0, 0};
  int m_tage [2] = '{0, 0};
  bit m_go_idle [2] = '{0, 0};
  bit m_go_next [2] = '{0, 0};
  bit m_ena [2] = '{0, 0};
  bit m_inj [2] = '{0, 0};

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc_n);
  endtask

  function automatic logic [17:0] obs(input int i);
    return {seq_o[i], stall_o[i], rst_o[i], zeros_o[i], a_o[i], b_o[i], sync_o[i],
            train_o[i], done_o[i], failed_o[i], eena_o[i], inj_o[i]};
  endfunction

  function automatic logic [17:0] expv(input int i);
    logic [10:0] f;
    f = '0;
    case (m_st[i])
      S_IDLE:   begin f[B_RST] = 1'b1; f[B_ZEROS] = 1'b1; end
      S_PAT_A:  f[B_A] = 1'b1;
      S_PAT_B:  f[B_B] = 1'b1;
      S_SYNC:   f[B_SYNC] = 1'b1;
      S_TRAIN:  f[B_TRAIN] = 1'b1;
      S_RUN:    f[B_DONE] = 1'b1;
      default:  begin f[B_ZEROS] = 1'b1; f[B_FAILED] = 1'b1; end
    endcase
    f[B_STALL] = (m_pos[i] >= 64);
    f[B_ENA] = m_ena[i];
    f[B_INJ] = m_inj[i];
    return {7'(m_pos[i]), f};
  endfunction

  task automatic model_step(input int i);
    int nxt;
    bit trn, adv, leave, at_edge;
    if (dlx_reset) begin
      m_st[i] = S_IDLE; m_pos[i] = 0; m_age[i] = 0; m_tage[i] = 0;
      m_go_idle[i] = 0; m_go_next[i] = 0; m_ena[i] = 0; m_inj[i] = 0;
      return;
    end
    trn = (m_st[i] >= S_PAT_A) && (m_st[i] <= S_TRAIN);
    at_edge = (m_pos[i] == 65);
    adv = 0;
    leave = 0;
    case (m_st[i])
      S_PAT_A: adv = (m_age[i] >= P_MIN) && pa_i[i];
      S_PAT_B: adv = (m_age[i] >= P_MIN) && pb_i[i];
      S_SYNC:  adv = (m_age[i] + 1 >= P_SYNC);
      S_TRAIN: adv = lu_i[i];
      default: adv = 0;
    endcase
    if (trn || m_st[i] == S_FAILED) leave = !st_i[i];
    if (m_st[i] == S_RUN) leave = !st_i[i] || !lu_i[i];
    leave = leave || m_go_idle[i];
    adv = adv || m_go_next[i];
    nxt = m_st[i];
    if (m_st[i] == S_IDLE) begin
      if (st_i[i]) nxt = S_PAT_A;
    end else if ((trn || m_st[i] == S_RUN) && fl_i[i]) nxt = S_FAILED;
    else if (trn && (m_tage[i] + 1 >= p_tmo[i])) nxt = S_FAILED;
    else if (at_edge && leave) nxt = S_IDLE;
    else if (at_edge && adv && trn) nxt = m_st[i] + 1;
    if (EDPL) begin
      if (nxt != S_RUN) m_inj[i] = 0;
      else if (m_inj[i]) m_inj[i] = !hw_i[i];
      else m_inj[i] = req_i[i] && m_ena[i] && (m_st[i] == S_RUN);
      m_ena[i] = ena_i[i];
    end
    m_pos[i] = (m_st[i] == S_IDLE) ? 0 : (m_pos[i] + 1) % 66;
    if (nxt != m_st[i]) begin
      m_age[i] = 0; m_go_idle[i] = 0; m_go_next[i] = 0;
    end else begin
      m_age[i] = (m_age[i] < 65535) ? m_age[i] + 1 : 65535;
      m_go_idle[i] = leave;
      m_go_next[i] = adv;
    end
    m_tage[i] = (trn && nxt >= S_PAT_A && nxt <= S_TRAIN) ? m_tage[i] + 1 : 0;
    m_st[i] = nxt;
  endtask

  task automatic cyc();
    @(posedge dlx_clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge dlx_clk);
    cyc_n++;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("outs_u%0d", i), int'(obs(i)), int'(expv(i)));
      if (fail_at[i] < 0 && failed_o[i]) fail_at[i] = cyc_n;
    end
  endtask

  task automatic wait_bit(input int i, input int b, input int budget, input string tag);
    int n;
    logic [17:0] v;
    n = 0;
    v = obs(i);
    while (v[b] == 1'b0 && n < budget) begin
      cyc();
      n++;
      v = obs(i);
    end
    check_val(tag, int'(v[b]), 1);
  endtask

  task automatic wait_seq(input int i, input int s, input int budget);
    int n;
    n = 0;
    while (int'(seq_o[i]) != s && n < budget) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int t0, tb, n, seq_err, n_stall, a_err;
    for (int i = 0; i < 2; i++) begin
      st_i[i] = 0; pa_i[i] = 0; pb_i[i] = 0; lu_i[i] = 0;
      fl_i[i] = 0; ena_i[i] = 0; req_i[i] = 0; hw_i[i] = 0;
    end
    repeat (3) cyc();
    dlx_reset = 1'b0;
    repeat (200) cyc();
    check_val("idle_seq", int'(seq_o[0]), 0);
    check_val("idle_gb_reset", int'(rst_o[0]), 1);
    check_val("idle_zeros", int'(zeros_o[0]), 1);
    check_val("idle_a_pat", int'(a_o[0]), 0);

    // Training walk on u0; u1 never sees pattern A and must time out.
    st_i[0] = 1; st_i[1] = 1;
    cyc();
    t0 = cyc_n;
    seq_err = 0; n_stall = 0; a_err = 0;
    while (!b_o[0] && cyc_n - t0 < 300) begin
      if (cyc_n - t0 == 50) pa_i[0] = 1;
      if (int'(seq_o[0]) != (cyc_n - t0) % 66) seq_err++;
      if (stall_o[0]) n_stall++;
      if (!a_o[0]) a_err++;
      cyc();
    end
    check_val("patb_entry_cyc", cyc_n - t0, 132);
    check_val("patb_seq", int'(seq_o[0]), 0);
    check_val("pata_seq_walk", seq_err, 0);
    check_val("pata_stall_cnt", n_stall, 4);
    check_val("pata_select", a_err, 0);

    repeat ($urandom_range(0, 120)) cyc();
    pb_i[0] = 1;
    wait_bit(0, B_SYNC, 300, "wait_sync");
    tb = cyc_n;
    wait_bit(0, B_TRAIN, 200, "wait_train");
    check_val("sync_len", cyc_n - tb, 66);
    check_val("u1_tmo_cyc", fail_at[1] - t0, 300);
    check_val("u1_failed", int'(failed_o[1]), 1);
    check_val("u1_fail_zeros", int'(zeros_o[1]), 1);
    st_i[1] = 0;
    wait_bit(1, B_RST, 80, "u1_back_idle");
    check_val("u1_idle_seq", int'(seq_o[1]), 0);

    repeat ($urandom_range(0, 80)) cyc();
    lu_i[0] = 1;
    wait_bit(0, B_DONE, 250, "wait_run");
    check_val("run_no_train", int'(train_o[0]), 0);

    // EDPL inject handshake in RUN.
    ena_i[0] = 1;
    cyc(); cyc();
    check_val("edpl_ena", int'(eena_o[0]), int'(EDPL));
    req_i[0] = 1; cyc(); req_i[0] = 0;
    check_val("edpl_inj_set", int'(inj_o[0]), int'(EDPL));
    cyc();
    req_i[0] = 1; cyc(); req_i[0] = 0; cyc();
    check_val("edpl_inj_hold", int'(inj_o[0]), int'(EDPL));
    hw_i[0] = 1; cyc(); hw_i[0] = 0;
    check_val("edpl_inj_clr", int'(inj_o[0]), 0);
    repeat (3) cyc();
    check_val("edpl_req_dropped", int'(inj_o[0]), 0);

    // Failure mid-frame in TRAIN is immediate.
    st_i[0] = 0;
    wait_bit(0, B_RST, 80, "u0_idle_1");
    st_i[0] = 1;
    wait_bit(0, B_TRAIN, 500, "wait_train_2");
    wait_seq(0, 10, 80);
    fl_i[0] = 1; cyc(); fl_i[0] = 0;
    check_val("trn_fail_now", int'(failed_o[0]), 1);
    check_val("trn_fail_seq", int'(seq_o[0]), 11);

    // Failure beats a simultaneous PAT_B advance at the boundary.
    st_i[0] = 0;
    wait_bit(0, B_RST, 80, "u0_idle_2");
    st_i[0] = 1;
    wait_bit(0, B_B, 200, "wait_patb_2");
    tb = cyc_n;
    n = 0;
    while (!(int'(seq_o[0]) == 65 && cyc_n - tb >= 131) && n < 300) begin
      cyc();
      n++;
    end
    fl_i[0] = 1; cyc(); fl_i[0] = 0;
    check_val("patb_fail_wins", int'(failed_o[0]), 1);
    check_val("patb_no_sync", int'(sync_o[0]), 0);

    // Randomized levels on both instances, one async reset midway.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 299) == 0) st_i[i] = !st_i[i];
        if ($urandom_range(0, 39) == 0) pa_i[i] = !pa_i[i];
        if ($urandom_range(0, 39) == 0) pb_i[i] = !pb_i[i];
        if ($urandom_range(0, 59) == 0) lu_i[i] = !lu_i[i];
        if ($urandom_range(0, 49) == 0) ena_i[i] = !ena_i[i];
        fl_i[i] = ($urandom_range(0, 399) == 0);
        req_i[i] = ($urandom_range(0, 7) == 0);
        hw_i[i] = ($urandom_range(0, 5) == 0);
      end
      if (k == 1500) dlx_reset = 1'b1;
      if (k == 1503) dlx_reset = 1'b0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
